// File: rtl/axi4_wr_slave_if.sv
// AXI4 write-channel bundle (AW, W, B) for axi4_wr_slave.
// The master modport drives requests; the slave modport is the memory side.
interface axi4_wr_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi4_wr_slave.sv
// AXI4 write-only slave backed by an internal word memory, one transaction at a time.
// Optional WLAST checking is enabled by defining KVIPS_AXI4_WR_SLAVE_WLAST_CHK_EN.
module axi4_wr_slave #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       ID_W      = 4,
  parameter int unsigned       MEM_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         aclk,
  input  logic                         areset,
  axi4_wr_slave_if.slave               bus,
  input  logic [$clog2(MEM_WORDS)-1:0] rd_idx,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         err_wlast
);
  localparam int unsigned   StrbW    = DATA_W / 8;
  localparam int unsigned   OffW     = $clog2(StrbW);
  localparam int unsigned   IdxW     = $clog2(MEM_WORDS);
  localparam logic [2:0]    MaxSize  = 3'(OffW);
  localparam logic [ADDR_W:0] MemWords = (ADDR_W + 1)'(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              bad_q, bad_d;  // illegal AW attributes: consume beats, write nothing

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              aw_hs, w_hs, b_hs, last_beat, bad_cfg, in_range, wr_en, wlast_err;
  logic [ADDR_W-1:0] beat_bytes, aligned, incr_addr, wrap_mask, next_addr, off, word_off;
  logic [IdxW-1:0]   wr_idx;
  logic [DATA_W-1:0] wr_word;

  always_comb begin
    bus.awready = !areset && (state_q == StIdle);
    bus.wready  = !areset && (state_q == StData);
    bus.bvalid  = !areset && (state_q == StResp);
    bus.bid     = '0;
    bus.bresp   = 2'b00;
    if (bus.bvalid) begin
      bus.bid   = id_q;
      bus.bresp = err_q ? 2'b10 : 2'b00;
    end
  end

  assign aw_hs     = bus.awvalid && bus.awready;
  assign w_hs      = bus.wvalid && bus.wready;
  assign b_hs      = bus.bvalid && bus.bready;
  assign last_beat = (cnt_q == len_q);

  assign bad_cfg = (bus.awburst == 2'b11) || (bus.awsize > MaxSize) ||
                   ((bus.awburst == 2'b10) && !((bus.awlen == 8'd1) || (bus.awlen == 8'd3) ||
                                                (bus.awlen == 8'd7) || (bus.awlen == 8'd15)));

`ifdef KVIPS_AXI4_WR_SLAVE_WLAST_CHK_EN
  assign wlast_err = w_hs && (bus.wlast != last_beat);
`else
  logic unused_wlast;
  assign unused_wlast = bus.wlast;
  assign wlast_err    = 1'b0;
`endif
  assign err_wlast = wlast_err;

  // WRAP keeps the upper address bits of the (len+1)*size window and wraps the low bits.
  always_comb begin
    beat_bytes = ADDR_W'(1) << size_q;
    aligned    = addr_q & ~(beat_bytes - ADDR_W'(1));
    incr_addr  = aligned + beat_bytes;
    wrap_mask  = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    unique case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
    off      = addr_q - BASE_ADDR;
    word_off = off >> OffW;
    in_range = (addr_q >= BASE_ADDR) && ({1'b0, word_off} < MemWords);
    wr_idx   = word_off[IdxW-1:0];
    wr_en    = w_hs && !bad_q && in_range;
  end

  always_comb begin
    wr_word = mem_q[wr_idx];
    for (int b = 0; b < StrbW; b++) begin
      if (bus.wstrb[b]) wr_word[b*8 +: 8] = bus.wdata[b*8 +: 8];
    end
    rd_data_d = (wr_en && (wr_idx == rd_idx)) ? wr_word : mem_q[rd_idx];
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    bad_d   = bad_q;
    unique case (state_q)
      StIdle: begin
        if (aw_hs) begin
          id_d    = bus.awid;
          addr_d  = bus.awaddr;
          len_d   = bus.awlen;
          size_d  = bus.awsize;
          burst_d = bus.awburst;
          cnt_d   = '0;
          err_d   = bad_cfg;
          bad_d   = bad_cfg;
          state_d = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          cnt_d  = cnt_q + 8'd1;
          addr_d = next_addr;
          err_d  = err_q || (!bad_q && !in_range) || wlast_err;
          if (last_beat) state_d = StResp;
        end
      end
      StResp: begin
        if (b_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
    end
  end

  // Memory and read port survive reset on purpose.
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_idx] <= wr_word;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_axi4_wr_slave.sv
// Self-checking bench for axi4_wr_slave: scoreboard of expected B responses plus a memory model.
module tb_axi4_wr_slave;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned MW = 256;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  rd_idx;
  logic [63:0] rd_data;
  logic        err_wlast;

  b_exp_t      sb[$];
  logic [63:0] model [MW];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  axi4_wr_slave_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

  axi4_wr_slave #(
    .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MEM_WORDS(MW), .BASE_ADDR(32'h0)
  ) dut (
    .aclk(clk), .areset(areset), .bus(bus),
    .rd_idx(rd_idx), .rd_data(rd_data), .err_wlast(err_wlast)
  );

`ifdef KVIPS_AXI4_WR_SLAVE_WLAST_CHK_EN
  localparam bit WlastChk = 1'b1;
`else
  localparam bit WlastChk = 1'b0;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- drivers ----------------
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
    b_exp_t e;
    int n = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    #1;
    while (bus.awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin n_checks++; $display("FAIL aw_timeout awready=%b want 1", bus.awready); end
    e.id = id; e.resp = resp;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic wbeat(input logic [63:0] data, input logic [7:0] strb, input logic last,
                       input int idx, input bit exp_wr, output logic ew);
    int n = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    #1;
    while (bus.wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin n_checks++; $display("FAIL w_timeout wready=%b want 1", bus.wready); end
    ew = err_wlast;
    if (exp_wr) begin
      for (int b = 0; b < 8; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic get_b(output logic [3:0] id, output logic [1:0] resp);
    int n = 0;
    bus.bready = 1'b1;
    while (bus.bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      n_checks++;
      $display("FAIL b_timeout bvalid=%b want 1", bus.bvalid);
      id = 'x; resp = 'x;
    end else begin
      id = bus.bid; resp = bus.bresp;
    end
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic peek(input int idx, output logic [63:0] d);
    rd_idx = 8'(idx);
    @(posedge clk); #1;
    d = rd_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 6;
    if (bus.awready !== 1'b0) $display("FAIL rst_awready got %b want 0", bus.awready); else n_pass++;
    if (bus.wready !== 1'b0) $display("FAIL rst_wready got %b want 0", bus.wready); else n_pass++;
    if (bus.bvalid !== 1'b0) $display("FAIL rst_bvalid got %b want 0", bus.bvalid); else n_pass++;
    if (bus.bid !== 4'h0) $display("FAIL rst_bid got %h want 0", bus.bid); else n_pass++;
    if (bus.bresp !== 2'b00) $display("FAIL rst_bresp got %b want 00", bus.bresp); else n_pass++;
    if (err_wlast !== 1'b0) $display("FAIL rst_err_wlast got %b want 0", err_wlast); else n_pass++;
    areset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.awready !== 1'b1) $display("FAIL rst_release_awready got %b want 1", bus.awready);
    else n_pass++;
  endtask

  // Preload every word through one maximum-length INCR burst.
  task automatic test_fill();
    logic ew; logic [3:0] oid; logic [1:0] oresp; logic [63:0] d; b_exp_t e;
    send_aw(4'h1, 32'h0, 8'd255, 3'd3, 2'b01, 2'b00);
    for (int i = 0; i < 256; i++) wbeat(64'hF00D_0000_0000_0000 | 64'(i), 8'hFF, i == 255, i, 1'b1, ew);
    get_b(oid, oresp); e = sb.pop_front();
    n_checks++;
    if ({oid, oresp} !== {e.id, e.resp})
      $display("FAIL fill_b got id=%h resp=%b want id=%h resp=%b", oid, oresp, e.id, e.resp);
    else n_pass++;
    foreach (model[i]) if (i % 85 == 0) begin
      peek(i, d); n_checks++;
      if (d !== model[i]) $display("FAIL fill_word%0d got %h want %h", i, d, model[i]); else n_pass++;
    end
  endtask

  task automatic test_incr();
    logic ew; logic [3:0] oid; logic [1:0] oresp; logic [63:0] d; b_exp_t e;
    send_aw(4'h5, 32'h10, 8'd3, 3'd3, 2'b01, 2'b00);
    n_checks++;
    if (bus.wready !== 1'b1) $display("FAIL incr_wready_lat got %b want 1", bus.wready); else n_pass++;
    for (int i = 0; i < 4; i++) wbeat(64'(10 + i), 8'hFF, i == 3, 2 + i, 1'b1, ew);
    n_checks++;
    if (bus.bvalid !== 1'b1) $display("FAIL incr_bvalid_lat got %b want 1", bus.bvalid); else n_pass++;
    get_b(oid, oresp); e = sb.pop_front();
    n_checks++;
    if ({oid, oresp} !== {e.id, e.resp})
      $display("FAIL incr_b got id=%h resp=%b want id=%h resp=%b", oid, oresp, e.id, e.resp);
    else n_pass++;
    for (int i = 1; i < 7; i++) begin
      peek(i, d); n_checks++;
      if (d !== model[i]) $display("FAIL incr_word%0d got %h want %h", i, d, model[i]); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic ew; logic [3:0] oid; logic [1:0] oresp; logic [63:0] d; b_exp_t e;
    int order[4] = '{3, 0, 1, 2};
    send_aw(4'h6, 32'h18, 8'd3, 3'd3, 2'b10, 2'b00);
    for (int i = 0; i < 4; i++) wbeat(64'h100 + 64'(i), 8'hFF, i == 3, order[i], 1'b1, ew);
    get_b(oid, oresp); e = sb.pop_front();
    n_checks++;
    if ({oid, oresp} !== {e.id, e.resp})
      $display("FAIL wrap_b got id=%h resp=%b want id=%h resp=%b", oid, oresp, e.id, e.resp);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      peek(i, d); n_checks++;
      if (d !== model[i]) $display("FAIL wrap_word%0d got %h want %h", i, d, model[i]); else n_pass++;
    end
  endtask

  // 4-byte beats share 8-byte words; lane strobes pick halves, last strobe is empty.
  task automatic test_narrow_strb();
    logic ew; logic [3:0] oid; logic [1:0] oresp; logic [63:0] d; b_exp_t e;
    logic [7:0] strb[4] = '{8'h0F, 8'hF0, 8'h0F, 8'h00};
    int idx[4] = '{10, 10, 11, 11};
    send_aw(4'h7, 32'h50, 8'd3, 3'd2, 2'b01, 2'b00);
    for (int i = 0; i < 4; i++)
      wbeat({32'hA0 + 32'(i), 32'hB0 + 32'(i)}, strb[i], i == 3, idx[i], 1'b1, ew);
    get_b(oid, oresp); e = sb.pop_front();
    n_checks++;
    if ({oid, oresp} !== {e.id, e.resp})
      $display("FAIL narrow_b got id=%h resp=%b want id=%h resp=%b", oid, oresp, e.id, e.resp);
    else n_pass++;
    for (int i = 10; i < 13; i++) begin
      peek(i, d); n_checks++;
      if (d !== model[i]) $display("FAIL narrow_word%0d got %h want %h", i, d, model[i]); else n_pass++;
    end
  endtask

  task automatic test_fixed();
    logic ew; logic [3:0] oid; logic [1:0] oresp; logic [63:0] d; b_exp_t e;
    send_aw(4'h8, 32'h60, 8'd2, 3'd3, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) wbeat(64'(i + 1), 8'hFF, i == 2, 12, 1'b1, ew);
    get_b(oid, oresp); e = sb.pop_front();
    n_checks++;
    if ({oid, oresp} !== {e.id, e.resp})
      $display("FAIL fixed_b got id=%h resp=%b want id=%h resp=%b", oid, oresp, e.id, e.resp);
    else n_pass++;
    for (int i = 12; i < 14; i++) begin
      peek(i, d); n_checks++;
      if (d !== model[i]) $display("FAIL fixed_word%0d got %h want %h", i, d, model[i]); else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    logic ew; logic [3:0] oid; logic [1:0] oresp; logic [63:0] d; b_exp_t e;
    send_aw(4'h9, 32'h800, 8'd0, 3'd3, 2'b01, 2'b10);
    wbeat(64'hDEAD_BEEF, 8'hFF, 1'b1, 0, 1'b0, ew);
    get_b(oid, oresp); e = sb.pop_front();
    n_checks++;
    if ({oid, oresp} !== {e.id, e.resp})
      $display("FAIL oor_b got id=%h resp=%b want id=%h resp=%b", oid, oresp, e.id, e.resp);
    else n_pass++;
    // Straddles the top: first beat lands in word 255, second falls off the end.
    send_aw(4'h3, 32'h7F8, 8'd1, 3'd3, 2'b01, 2'b10);
    wbeat(64'h5555_AAAA, 8'hFF, 1'b0, 255, 1'b1, ew);
    wbeat(64'h6666_BBBB, 8'hFF, 1'b1, 0, 1'b0, ew);
    get_b(oid, oresp); e = sb.pop_front();
    n_checks++;
    if ({oid, oresp} !== {e.id, e.resp})
      $display("FAIL edge_b got id=%h resp=%b want id=%h resp=%b", oid, oresp, e.id, e.resp);
    else n_pass++;
    foreach (model[i]) if (i == 0 || i == 255) begin
      peek(i, d); n_checks++;
      if (d !== model[i]) $display("FAIL oor_word%0d got %h want %h", i, d, model[i]); else n_pass++;
    end
  endtask

  task automatic test_bad_cfg();
    logic ew; logic [3:0] oid; logic [1:0] oresp; logic [63:0] d; b_exp_t e;
    logic [1:0] burst[3] = '{2'b11, 2'b10, 2'b01};
    logic [7:0] len[3]   = '{8'd1, 8'd2, 8'd0};
    logic [2:0] size[3]  = '{3'd3, 3'd3, 3'd4};
    for (int t = 0; t < 3; t++) begin
      send_aw(4'(t + 12), 32'h0, len[t], size[t], burst[t], 2'b10);
      for (int i = 0; i <= int'(len[t]); i++)
        wbeat(64'hBAD0 + 64'(i), 8'hFF, i == int'(len[t]), 0, 1'b0, ew);
      get_b(oid, oresp); e = sb.pop_front();
      n_checks++;
      if ({oid, oresp} !== {e.id, e.resp})
        $display("FAIL badcfg%0d_b got id=%h resp=%b want id=%h resp=%b",
                 t, oid, oresp, e.id, e.resp);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      peek(i, d); n_checks++;
      if (d !== model[i]) $display("FAIL badcfg_word%0d got %h want %h", i, d, model[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic ew; b_exp_t e;
    send_aw(4'hA, 32'h80, 8'd0, 3'd3, 2'b01, 2'b00);
    wbeat(64'h1234_5678, 8'hFF, 1'b1, 16, 1'b1, ew);
    e = sb.pop_front();
    bus.bready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus.bvalid !== 1'b1 || bus.bid !== e.id || bus.bresp !== e.resp || bus.awready !== 1'b0)
        $display("FAIL bp_hold%0d got v=%b id=%h resp=%b awr=%b want v=1 id=%h resp=%b awr=0",
                 c, bus.bvalid, bus.bid, bus.bresp, bus.awready, e.id, e.resp);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    n_checks++;
    if (bus.awready !== 1'b1 || bus.bvalid !== 1'b0)
      $display("FAIL bp_release got awr=%b v=%b want awr=1 v=0", bus.awready, bus.bvalid);
    else n_pass++;
  endtask

  task automatic test_wlast();
    logic ew; logic [3:0] oid; logic [1:0] oresp; logic [63:0] d; b_exp_t e;
    logic exp_ew;
    send_aw(4'hB, 32'hA0, 8'd3, 3'd3, 2'b01, WlastChk ? 2'b10 : 2'b00);
    for (int i = 0; i < 4; i++) begin
      wbeat(64'h77 + 64'(i), 8'hFF, (i == 1) || (i == 3), 20 + i, 1'b1, ew);
      exp_ew = WlastChk && (i == 1);
      n_checks++;
      if (ew !== exp_ew) $display("FAIL wlast_pulse%0d got %b want %b", i, ew, exp_ew); else n_pass++;
    end
    get_b(oid, oresp); e = sb.pop_front();
    n_checks++;
    if ({oid, oresp} !== {e.id, e.resp})
      $display("FAIL wlast_b got id=%h resp=%b want id=%h resp=%b", oid, oresp, e.id, e.resp);
    else n_pass++;
    peek(23, d); n_checks++;
    if (d !== model[23]) $display("FAIL wlast_word23 got %h want %h", d, model[23]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic ew; logic [3:0] oid; logic [1:0] oresp; logic [63:0] d; b_exp_t e;
    send_aw(4'hC, 32'h100, 8'd3, 3'd3, 2'b01, 2'b00);
    wbeat(64'hC0, 8'hFF, 1'b0, 32, 1'b1, ew);
    wbeat(64'hC1, 8'hFF, 1'b0, 33, 1'b1, ew);
    void'(sb.pop_back());
    areset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.bvalid !== 1'b0 || bus.awready !== 1'b0 || bus.wready !== 1'b0)
        $display("FAIL midrst_hold%0d got v=%b awr=%b wr=%b want 0 0 0",
                 c, bus.bvalid, bus.awready, bus.wready);
      else n_pass++;
    end
    areset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.awready !== 1'b1 || bus.bvalid !== 1'b0)
      $display("FAIL midrst_release got awr=%b v=%b want awr=1 v=0", bus.awready, bus.bvalid);
    else n_pass++;
    for (int i = 32; i < 35; i++) begin
      peek(i, d); n_checks++;
      if (d !== model[i]) $display("FAIL midrst_word%0d got %h want %h", i, d, model[i]); else n_pass++;
    end
    // A fresh transaction must complete normally after the abandoned one.
    send_aw(4'hD, 32'h110, 8'd0, 3'd3, 2'b01, 2'b00);
    wbeat(64'hC2C2, 8'h3C, 1'b1, 34, 1'b1, ew);
    get_b(oid, oresp); e = sb.pop_front();
    n_checks++;
    if ({oid, oresp} !== {e.id, e.resp})
      $display("FAIL midrst_b got id=%h resp=%b want id=%h resp=%b", oid, oresp, e.id, e.resp);
    else n_pass++;
    peek(34, d); n_checks++;
    if (d !== model[34]) $display("FAIL midrst_word34 got %h want %h", d, model[34]); else n_pass++;
  endtask

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; rd_idx = '0;
    foreach (model[i]) model[i] = 'x;
    test_reset();
    test_fill();
    test_incr();
    test_wrap();
    test_narrow_strb();
    test_fixed();
    test_out_of_range();
    test_bad_cfg();
    test_backpressure();
    test_wlast();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
